corr_chan_n: RTL and testbench
==============================

CORR_CHAN_N -- requirements
Module: corr_chan_n

Interface
REQ-001 SHALL have parameter NTAPS, default 3, number of correlator taps (odd, 3..7), spaced one half-chip apart; tap (NTAPS-1)/2 is prompt.
REQ-002 SHALL have parameter ACC_BITS, default 18, width of each I/Q accumulator.
REQ-003 SHALL have parameter CODELEN, default 1023, code length in chips.
REQ-004 SHALL have parameter CODEBITS, default 13, width of the chip index.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sample  input  1  1-bit IF sample, valid every clk.
REQ-008 SHALL have ports wrReg  input  1, op  input  16, tos  input  32  register write strobe, op-bit select, write data.
REQ-009 SHALL have port cg_resume  input  1  re-enables a paused code NCO.
REQ-010 SHALL have port code_chip  input  1  code bit for the current nchip, from an external code table, valid the cycle after nchip changes.
REQ-011 SHALL have port nchip  output  CODEBITS  current chip index.
REQ-012 SHALL have port ms0  output  1  one-cycle code-epoch pulse.
REQ-013 SHALL have ports shift  input  1, sout  output  1  serial readout of the dump register, MSB first.
REQ-014 SHALL have ports dump_rdy  output  1, overrun  output  1  dump pulse; sticky unread-dump-overwritten flag.

Function
REQ-015 SHALL write lo_rate on op[SET_LO_NCO], cg_rate on op[SET_CG_NCO], integ_n = tos[3:0] on op[SET_INTEG] (integration = integ_n+1 epochs, 1..16).
REQ-016 SHALL add cg_rate to 32-bit cg_phase each cycle while cg_en; half-chip event = change of cg_phase[31]; full-chip event = carry out of bit 31.
REQ-017 SHALL clear cg_en on op[SET_PAUSE] and set it when cg_resume is high; a simultaneous pause write wins; while paused, cg_phase, nchip and taps hold and accumulators keep running.
REQ-018 SHALL increment nchip on each full-chip event, wrapping CODELEN-1 -> 0; ms0 SHALL pulse the cycle after the wrap.
REQ-019 SHALL latch code_chip on each full-chip event; on each half-chip event shift the NTAPS-bit tap line, tap[0] <= latched chip, tap[k] <= tap[k-1].
REQ-020 SHALL derive LO_I/LO_Q from lo_phase[31:30] via the quadrature tables 1100/0110; lo_phase accumulates lo_rate every cycle.
REQ-021 SHALL register mixer bits dI[k] = sample^tap[k]^LO_I, dQ[k] = sample^tap[k]^LO_Q one cycle before accumulation.
REQ-022 SHALL add +1 when mixer bit is 0 and -1 when 1, two's-complement wrap at ACC_BITS, no saturation.
REQ-023 SHALL count epochs; on the ms0 pulse completing integ_n+1 epochs: copy all accumulators into the dump register, restart accumulators with the current cycle's contribution only, pulse dump_rdy for one cycle.
REQ-024 SHALL order the dump register I[0],Q[0],I[1],Q[1],...,Q[NTAPS-1], each MSB first; total 2*NTAPS*ACC_BITS bits; each shift high moves one bit; sout is its MSB; shifting beyond the end yields 0.
REQ-025 SHALL set overrun when a dump occurs before 2*NTAPS*ACC_BITS shifts since the previous dump; cleared only by rst or op[SET_INTEG].
REQ-026 SHALL restart the epoch count at 0 and clear accumulators on op[SET_INTEG] write, without producing a dump.

Reset
REQ-027 SHALL on rst zero cg_phase, lo_phase, rates, nchip, taps, accumulators, dump register, epoch count, integ_n; ms0, dump_rdy, overrun, sout = 0; cg_en = 1.
REQ-028 SHALL let rst override every concurrent write, shift or event in the same cycle.

Structure
REQ-029 SHALL take op-bit indices SET_LO_NCO, SET_CG_NCO, SET_PAUSE, SET_INTEG and the default ACC_BITS/CODELEN/CODEBITS from the shared GPS constants package.
REQ-030 SHALL instantiate one sub-module corr_acc (mixer pair plus I/Q accumulator pair), NTAPS times via generate.

Verification
REQ-031 SHALL test: cg_rate=0x40000000, CODELEN=1023 -> nchip increments every 4 clk, wraps 1022->0, ms0 one pulse per 4092 clk.
REQ-032 SHALL test: sample=0, code_chip=0, lo_rate=0, integ_n=0 -> at dump, prompt I = +4092, Q = +4092 (LO_I=LO_Q=0 at phase 0).
REQ-033 SHALL test: integ_n=3, no shifting -> dump_rdy every 4 epochs, overrun set at second dump, cleared by SET_INTEG write.
REQ-034 SHALL test: pause write with cg_resume high same cycle -> cg_en 0, nchip frozen; cg_resume next cycle -> advance resumes.
REQ-035 SHALL test: NTAPS=5, single-chip code pulse -> tap[k] rises k half-chips after the latching full-chip event.
REQ-036 SHALL test: rst asserted mid-integration with shift high -> all outputs 0 next cycle, no dump_rdy.

Source files
------------

// File: rtl/corr_chan_n_pkg.sv
// Shared GPS constants for the correlator channel.
// Holds the register-write op-bit indices, the default accumulator / code-length
// widths and the local-oscillator quadrature tables.
package corr_chan_n_pkg;

    // Bit positions inside the 16-bit op word of a register write.
    localparam int unsigned SET_LO_NCO = 0;
    localparam int unsigned SET_CG_NCO = 1;
    localparam int unsigned SET_PAUSE  = 2;
    localparam int unsigned SET_INTEG  = 3;

    // Default channel geometry (C/A code).
    localparam int unsigned ACC_BITS_DEF = 18;
    localparam int unsigned CODELEN_DEF  = 1023;
    localparam int unsigned CODEBITS_DEF = 13;

    // LO sign bits indexed by lo_phase[31:30]; both are 0 at phase 0.
    localparam logic [3:0] LO_I_TABLE = 4'b1100;
    localparam logic [3:0] LO_Q_TABLE = 4'b0110;

endpackage

// File: rtl/corr_chan_n_acc.sv
// One correlator tap: registered I/Q mixer bits feeding a pair of +/-1 accumulators.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   sample_i           1-bit IF sample
//   tap_i              code replica bit for this tap
//   lo_i_i, lo_q_i     local-oscillator sign bits
//   clear_i            zero both accumulators
//   restart_i          restart both accumulators with this cycle's contribution
//   acc_i_o, acc_q_o   accumulator values
module corr_acc
    import corr_chan_n_pkg::*;
#(
    parameter int unsigned ACC_BITS = ACC_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sample_i,
    input  logic                tap_i,
    input  logic                lo_i_i,
    input  logic                lo_q_i,
    input  logic                clear_i,
    input  logic                restart_i,
    output logic [ACC_BITS-1:0] acc_i_o,
    output logic [ACC_BITS-1:0] acc_q_o
);

    logic                di_q, dq_q;
    logic [ACC_BITS-1:0] acc_i_q, acc_i_d;
    logic [ACC_BITS-1:0] acc_q_q, acc_q_d;
    logic [ACC_BITS-1:0] step_i, step_q;

    always_comb begin
        // Mixer bit 0 -> +1, 1 -> -1; wraps in two's complement.
        step_i = di_q ? {ACC_BITS{1'b1}} : ACC_BITS'(1);
        step_q = dq_q ? {ACC_BITS{1'b1}} : ACC_BITS'(1);
        acc_i_d = acc_i_q + step_i;
        acc_q_d = acc_q_q + step_q;
        if (clear_i) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (restart_i) begin
            acc_i_d = step_i;
            acc_q_d = step_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            di_q    <= 1'b0;
            dq_q    <= 1'b0;
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            di_q    <= sample_i ^ tap_i ^ lo_i_i;
            dq_q    <= sample_i ^ tap_i ^ lo_q_i;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end

    assign acc_i_o = acc_i_q;
    assign acc_q_o = acc_q_q;

endmodule

// File: rtl/corr_chan_n.sv
// GPS correlator channel: carrier NCO, code NCO with half-chip tap line,
// NTAPS I/Q accumulator pairs, epoch-based dump and serial readout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sample                   1-bit IF sample
//   wrReg, op, tos           register write strobe, op-bit select, write data
//   cg_resume                re-enable a paused code NCO
//   code_chip                code bit for the current nchip
//   nchip, ms0               chip index, code-epoch pulse
//   shift, sout              serial readout of the dump register, MSB first
//   dump_rdy, overrun        dump pulse, sticky unread-dump-overwritten flag
module corr_chan_n
    import corr_chan_n_pkg::*;
#(
    parameter int unsigned NTAPS    = 3,
    parameter int unsigned ACC_BITS = ACC_BITS_DEF,
    parameter int unsigned CODELEN  = CODELEN_DEF,
    parameter int unsigned CODEBITS = CODEBITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample,
    input  logic                wrReg,
    input  logic [15:0]         op,
    input  logic [31:0]         tos,
    input  logic                cg_resume,
    input  logic                code_chip,
    output logic [CODEBITS-1:0] nchip,
    output logic                ms0,
    input  logic                shift,
    output logic                sout,
    output logic                dump_rdy,
    output logic                overrun
);

    localparam int unsigned TOTAL = 2 * NTAPS * ACC_BITS;
    localparam int unsigned SCW   = $clog2(TOTAL + 1);

    logic wr_lo, wr_cg, wr_pause, wr_integ;
    logic unused_op;

    logic [31:0]         lo_rate_q, lo_rate_d, cg_rate_q, cg_rate_d;
    logic [31:0]         lo_phase_q, lo_phase_d, cg_phase_q, cg_phase_d;
    logic [32:0]         cg_sum;
    logic                cg_en_q, cg_en_d;
    logic                half_evt, full_evt;
    logic [CODEBITS-1:0] nchip_q, nchip_d;
    logic                ms0_q, ms0_d;
    logic                chip_q, chip_d;
    logic [NTAPS-1:0]    tap_q, tap_d;
    logic                lo_i, lo_q;
    logic [3:0]          integ_n_q, integ_n_d, epoch_q, epoch_d;
    logic                dump_evt;
    logic [TOTAL-1:0]    dump_q, dump_d, dump_load;
    logic                dump_rdy_q;
    logic                overrun_q, overrun_d;
    logic [SCW-1:0]      shift_cnt_q, shift_cnt_d;

    logic [ACC_BITS-1:0] acc_i [NTAPS];
    logic [ACC_BITS-1:0] acc_q [NTAPS];

    assign wr_lo     = wrReg & op[SET_LO_NCO];
    assign wr_cg     = wrReg & op[SET_CG_NCO];
    assign wr_pause  = wrReg & op[SET_PAUSE];
    assign wr_integ  = wrReg & op[SET_INTEG];
    assign unused_op = ^op;

    assign lo_i = LO_I_TABLE[lo_phase_q[31:30]];
    assign lo_q = LO_Q_TABLE[lo_phase_q[31:30]];

    // NCOs, code tracking and tap line.
    always_comb begin
        lo_rate_d  = wr_lo ? tos : lo_rate_q;
        cg_rate_d  = wr_cg ? tos : cg_rate_q;
        lo_phase_d = lo_phase_q + lo_rate_q;

        cg_sum   = {1'b0, cg_phase_q} + {1'b0, cg_rate_q};
        half_evt = cg_en_q & (cg_sum[31] ^ cg_phase_q[31]);
        full_evt = cg_en_q & cg_sum[32];
        cg_phase_d = cg_en_q ? cg_sum[31:0] : cg_phase_q;

        // Pause write beats a simultaneous resume.
        cg_en_d = cg_en_q;
        if (wr_pause) begin
            cg_en_d = 1'b0;
        end else if (cg_resume) begin
            cg_en_d = 1'b1;
        end

        nchip_d = nchip_q;
        ms0_d   = 1'b0;
        if (full_evt) begin
            if (nchip_q == CODEBITS'(CODELEN - 1)) begin
                nchip_d = '0;
                ms0_d   = 1'b1;
            end else begin
                nchip_d = nchip_q + CODEBITS'(1);
            end
        end

        // A full-chip event is also a half-chip event, so the freshly latched
        // chip enters tap[0] on the latching edge itself.
        chip_d = full_evt ? code_chip : chip_q;
        tap_d  = half_evt ? {tap_q[NTAPS-2:0], chip_d} : tap_q;
    end

    // Integration control, dump register and readout.
    always_comb begin
        integ_n_d = integ_n_q;
        epoch_d   = epoch_q;
        dump_evt  = 1'b0;
        if (wr_integ) begin
            integ_n_d = tos[3:0];
            epoch_d   = '0;
        end else if (ms0_q) begin
            if (epoch_q == integ_n_q) begin
                dump_evt = 1'b1;
                epoch_d  = '0;
            end else begin
                epoch_d = epoch_q + 4'd1;
            end
        end

        dump_load = '0;
        for (int k = 0; k < NTAPS; k++) begin
            dump_load[TOTAL - 1 - 2 * k * ACC_BITS -: ACC_BITS]       = acc_i[k];
            dump_load[TOTAL - 1 - (2 * k + 1) * ACC_BITS -: ACC_BITS] = acc_q[k];
        end

        dump_d      = dump_q;
        shift_cnt_d = shift_cnt_q;
        if (dump_evt) begin
            dump_d      = dump_load;
            shift_cnt_d = '0;
        end else if (shift) begin
            dump_d = dump_q << 1;
            if (shift_cnt_q != SCW'(TOTAL)) begin
                shift_cnt_d = shift_cnt_q + SCW'(1);
            end
        end

        overrun_d = overrun_q;
        if (wr_integ) begin
            overrun_d = 1'b0;
        end else if (dump_evt && (shift_cnt_q != SCW'(TOTAL))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_rate_q   <= '0;
            cg_rate_q   <= '0;
            lo_phase_q  <= '0;
            cg_phase_q  <= '0;
            cg_en_q     <= 1'b1;
            nchip_q     <= '0;
            ms0_q       <= 1'b0;
            chip_q      <= 1'b0;
            tap_q       <= '0;
            integ_n_q   <= '0;
            epoch_q     <= '0;
            dump_q      <= '0;
            dump_rdy_q  <= 1'b0;
            overrun_q   <= 1'b0;
            // Nothing is pending after reset, so the first dump cannot overrun.
            shift_cnt_q <= SCW'(TOTAL);
        end else begin
            lo_rate_q   <= lo_rate_d;
            cg_rate_q   <= cg_rate_d;
            lo_phase_q  <= lo_phase_d;
            cg_phase_q  <= cg_phase_d;
            cg_en_q     <= cg_en_d;
            nchip_q     <= nchip_d;
            ms0_q       <= ms0_d;
            chip_q      <= chip_d;
            tap_q       <= tap_d;
            integ_n_q   <= integ_n_d;
            epoch_q     <= epoch_d;
            dump_q      <= dump_d;
            dump_rdy_q  <= dump_evt;
            overrun_q   <= overrun_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        corr_acc #(
            .ACC_BITS(ACC_BITS)
        ) u_acc (
            .clk_i    (clk),
            .rst_i    (rst),
            .sample_i (sample),
            .tap_i    (tap_q[k]),
            .lo_i_i   (lo_i),
            .lo_q_i   (lo_q),
            .clear_i  (wr_integ),
            .restart_i(dump_evt),
            .acc_i_o  (acc_i[k]),
            .acc_q_o  (acc_q[k])
        );
    end

    assign nchip    = nchip_q;
    assign ms0      = ms0_q;
    assign sout     = dump_q[TOTAL-1];
    assign dump_rdy = dump_rdy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_corr_chan_n.sv
module tb_corr_chan_n;
    import corr_chan_n_pkg::*;

    localparam int unsigned NTAPS    = 5;
    localparam int unsigned ACC_BITS = 18;
    localparam int unsigned CODELEN  = 1023;
    localparam int unsigned CODEBITS = 13;
    localparam int unsigned TOTAL    = 2 * NTAPS * ACC_BITS;
    localparam int unsigned EPOCH    = 4 * CODELEN;
    localparam logic [15:0] OP_LO    = 16'(1 << SET_LO_NCO);
    localparam logic [15:0] OP_CG    = 16'(1 << SET_CG_NCO);
    localparam logic [15:0] OP_PAUSE = 16'(1 << SET_PAUSE);
    localparam logic [15:0] OP_INTEG = 16'(1 << SET_INTEG);

    logic                clk, rst, sample, wrReg, cg_resume, code_chip, shift;
    logic [15:0]         op;
    logic [31:0]         tos;
    logic [CODEBITS-1:0] nchip;
    logic                ms0, sout, dump_rdy, overrun;
    logic                code_en;

    // External code table: a single '1' chip at index 5.
    assign code_chip = code_en & (nchip == CODEBITS'(5));

    corr_chan_n #(
        .NTAPS   (NTAPS),
        .ACC_BITS(ACC_BITS),
        .CODELEN (CODELEN),
        .CODEBITS(CODEBITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sample   (sample),
        .wrReg    (wrReg),
        .op       (op),
        .tos      (tos),
        .cg_resume(cg_resume),
        .code_chip(code_chip),
        .nchip    (nchip),
        .ms0      (ms0),
        .shift    (shift),
        .sout     (sout),
        .dump_rdy (dump_rdy),
        .overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks, errors, cyc, exp_integ;
    bit mon_en;
    logic [ACC_BITS-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chip counter, epoch pulse and dump pulse against cycles since the rate write.
    task automatic mon_check();
        int period;
        period = EPOCH * (exp_integ + 1);
        check("nchip", 32'(nchip), 32'((cyc / 4) % CODELEN));
        check("ms0", 32'(ms0), 32'(cyc > 0 && cyc % EPOCH == 0));
        check("dump_rdy", 32'(dump_rdy), 32'(cyc > 1 && cyc % period == 1));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_en) mon_check();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1; wrReg = 1'b0; op = '0; tos = '0; cg_resume = 1'b0; shift = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic write_reg(input logic [15:0] op_v, input logic [31:0] tos_v);
        wrReg = 1'b1; op = op_v; tos = tos_v;
        tick();
        wrReg = 1'b0; op = '0; tos = '0;
    endtask

    // Code NCO at a quarter of clk (4 clk per chip); cyc 0 is the first cycle
    // with the new rate, phase 0 and cleared accumulators.
    task automatic start_run(input int integ);
        do_reset();
        write_reg(OP_CG | OP_INTEG, 32'h4000_0000);
        cyc = 0;
        exp_integ = integ;
        mon_en = 1'b1;
        mon_check();
        if (integ != 0) write_reg(OP_INTEG, 32'(integ));
    endtask

    task automatic read_dump();
        logic [ACC_BITS-1:0] word;
        for (int w = 0; w < 2 * NTAPS; w++) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'(1));
                return;
            end
            word = sb.pop_front();
            for (int b = ACC_BITS - 1; b >= 0; b--) begin
                check("sout_bit", 32'(sout), 32'(word[b]));
                shift = 1'b1;
                tick();
                shift = 1'b0;
            end
        end
        check("sout_past_end", 32'(sout), 32'(0));
        shift = 1'b1;
        tick();
        shift = 1'b0;
        check("sout_past_end2", 32'(sout), 32'(0));
    endtask

    initial begin
        logic [NTAPS-1:0] exp_tap;
        checks = 0; errors = 0; cyc = 0; exp_integ = 0; mon_en = 1'b0;
        sample = 1'b0; code_en = 1'b0;
        rst = 1'b1; wrReg = 1'b0; op = '0; tos = '0; cg_resume = 1'b0; shift = 1'b0;

        // Reset state.
        do_reset();
        check("rst_nchip", 32'(nchip), 32'(0));
        check("rst_ms0", 32'(ms0), 32'(0));
        check("rst_sout", 32'(sout), 32'(0));
        check("rst_dump_rdy", 32'(dump_rdy), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_cg_en", 32'(dut.cg_en_q), 32'(1));

        // Chip counting / epoch pulse, and a +4092 dump on every tap with all-zero
        // inputs and LO at phase 0; readout MSB first in I0,Q0,...,Q4 order.
        sample = 1'b0; code_en = 1'b0;
        start_run(0);
        run_to(EPOCH + 1);
        for (int i = 0; i < 2 * NTAPS; i++) sb.push_back(ACC_BITS'(4092));
        read_dump();
        run_to(2 * EPOCH + 1);
        check("overrun_after_read", 32'(overrun), 32'(0));

        // Pause with a simultaneous resume: pause wins, counter freezes.
        start_run(0);
        run_to(5);
        mon_en = 1'b0;
        wrReg = 1'b1; op = OP_PAUSE; cg_resume = 1'b1;
        tick();
        wrReg = 1'b0; op = '0; cg_resume = 1'b0;
        check("pause_cg_en", 32'(dut.cg_en_q), 32'(0));
        check("pause_nchip", 32'(nchip), 32'(1));
        repeat (10) tick();
        check("pause_hold", 32'(nchip), 32'(1));
        cg_resume = 1'b1;
        tick();
        cg_resume = 1'b0;
        check("resume_cg_en", 32'(dut.cg_en_q), 32'(1));
        check("resume_nchip0", 32'(nchip), 32'(1));
        tick();
        check("resume_nchip1", 32'(nchip), 32'(1));
        tick();
        check("resume_advance", 32'(nchip), 32'(2));

        // Single '1' chip at index 5, latched at the full-chip event ending chip 5.
        code_en = 1'b1;
        start_run(0);
        run_to(23);
        check("tap_before", 32'(dut.tap_q), 32'(0));
        for (int r = 0; r <= 12; r++) begin
            tick();
            for (int k = 0; k < NTAPS; k++) exp_tap[k] = (r >= 2 * k) && (r <= 2 * k + 3);
            check("tap_line", 32'(dut.tap_q), 32'(exp_tap));
        end
        code_en = 1'b0;

        // Four-epoch integration, never read: second dump overruns.
        start_run(3);
        run_to(4 * EPOCH + 1);
        check("ovr_first_dump", 32'(overrun), 32'(0));
        run_to(8 * EPOCH);
        check("ovr_before_second", 32'(overrun), 32'(0));
        tick();
        check("ovr_second_dump", 32'(overrun), 32'(1));
        write_reg(OP_INTEG, 32'(3));
        check("ovr_cleared", 32'(overrun), 32'(0));
        mon_en = 1'b0;

        // Negative correlation (sample=1), then reset on the cycle a dump would
        // occur with shift high.
        sample = 1'b1;
        start_run(0);
        run_to(EPOCH + 1);
        check("neg_sout_msb", 32'(sout), 32'(1));
        run_to(2 * EPOCH);
        mon_en = 1'b0;
        rst = 1'b1; shift = 1'b1;
        tick();
        check("mid_rst_nchip", 32'(nchip), 32'(0));
        check("mid_rst_ms0", 32'(ms0), 32'(0));
        check("mid_rst_sout", 32'(sout), 32'(0));
        check("mid_rst_dump_rdy", 32'(dump_rdy), 32'(0));
        check("mid_rst_overrun", 32'(overrun), 32'(0));
        rst = 1'b0; shift = 1'b0;
        tick();
        check("post_rst_dump_rdy", 32'(dump_rdy), 32'(0));
        check("post_rst_overrun", 32'(overrun), 32'(0));
        sample = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
